quad_step_decoder: RTL and testbench
====================================

# quad_step_decoder

Upstream front-end for the loadable up/down counter: converts raw asynchronous quadrature inputs (A, B) and an index pulse into one-cycle `countup`/`countdown`/`load` strobes in the counter's clock domain. It synchronises and glitch-filters every input and decodes Gray-code steps. It flags illegal double-transitions and reports the last valid direction. Its outputs connect directly to the counter's `load`, `countup` and `countdown` inputs.

## Interface
- `FILT_LEN`, default 3: consecutive cycles a synchronised input must differ from its filtered value before the filtered value flips. Range 1..15.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `a_in`  in  1  raw quadrature channel A (asynchronous).
- `b_in`  in  1  raw quadrature channel B (asynchronous).
- `idx_in`  in  1  raw index channel (asynchronous).
- `idx_en`  in  1  synchronous; when 1, a filtered index rising edge produces `load`.
- `err_clr`  in  1  synchronous; clears `err`.
- `countup`  out  1  one-cycle strobe, one forward step.
- `countdown`  out  1  one-cycle strobe, one reverse step.
- `load`  out  1  one-cycle strobe, index event.
- `dir`  out  1  last valid direction: 1 = up, 0 = down.
- `err`  out  1  sticky illegal-transition flag.

## Operation
- Reset (`rst`=0 at an edge) clears all state, including sync flops, filtered values, mismatch counters, prime counter and previous-state register.
- Every output is 0 in the cycle after a reset edge.
- Synchroniser: two flops per channel (a, b, idx).
- Filter, per channel:
  - Mismatch counter clears whenever sync2 == filt.
  - Otherwise the counter increments.
  - When it would reach FILT_LEN, filt takes sync2 and the counter clears.
- Priming: a prime counter runs after reset release. Decoding is inhibited (no strobes, no `err` set, `dir` held) until FILT_LEN+3 cycles have elapsed with `rst`=1. The previous-state register loads {filtA,filtB} every cycle, including while inhibited.
- Decode, with the previous state and current state written as {A,B}:
  - Forward sequence 00→10→11→01→00: `countup`=1 and `dir`=1.
  - Reverse sequence 00→01→11→10→00: `countdown`=1 and `dir`=0.
  - No change: no strobe.
  - Both bits change (00↔11, 10↔01): `err`=1, no strobe, `dir` unchanged.
- Index: filtered idx rising edge (0→1) with `idx_en`=1 and primed gives `load`=1.
- Simultaneous load and step: `load`=1 and both count strobes are forced to 0. The step is still absorbed into the previous-state register, so the index value takes precedence.
- `countup` and `countdown` are never both 1.
- `err`: a set and `err_clr` in the same cycle leave `err`=1. `err_clr` alone drives `err` to 0 at the next edge.

## Timing
- Raw change first captured by sync1 at edge k gives a strobe high for exactly the cycle after edge k+FILT_LEN+2. Latency is 5 cycles for FILT_LEN=3 and 3 cycles for FILT_LEN=1.
- Rejection: a pulse lasting fewer than FILT_LEN consecutive sync2 cycles produces no filtered change and no strobe.
- Maximum step rate: one step per FILT_LEN+1 cycles per channel. Faster input is undefined and may set `err`.
- All outputs are registered, with no combinational input-to-output path.
- Reset mid-operation: a strobe in flight is dropped and the block re-primes. No strobe occurs before FILT_LEN+3 cycles after release, even if inputs sit at 11.

## Structure
- Package `qsd_pkg`:
  - Gray state constants QS_00, QS_10, QS_11, QS_01.
  - Default FILT_LEN.
  - Function `qsd_step(prev,cur)` returning a 2-bit code {NONE, UP, DOWN, ILLEGAL}.
- Sub-module `qsd_sync_filter`: 2-flop synchroniser plus mismatch-counter filter for one bit, with a FILT_LEN parameter. It is instantiated three times.
- Top level holds the prime counter, previous-state register, decode/priority logic and output flops.

## Test plan
- Reset with a_in=b_in=1 held, release, wait 20 cycles, with FILT_LEN=3: no strobes and `err`=0 throughout.
- Forward sequence 00→10→11→01→00 on the raw inputs, each state held 8 cycles, after priming: four `countup` pulses, each 1 cycle wide, each 5 cycles after the raw edge; `dir`=1 and `countdown` never asserted.
- Reverse sequence, then a 2-cycle glitch on a_in: four `countdown` pulses and `dir`=0; the glitch produces no strobe.
- Raw a_in and b_in flip together 00→11 (both held 8 cycles): `err`=1 and no count strobe. Asserting `err_clr` for 1 cycle gives `err`=0 next cycle. `err_clr` coinciding with a new illegal event leaves `err`=1.
- idx_in pulse of 6 cycles with idx_en=1, coincident with a forward step: `load`=1 for 1 cycle with `countup`=0 that cycle. Repeating with idx_en=0 gives no `load`.
- `rst`=0 for 1 cycle while a step is 2 cycles from emerging: no strobe, all outputs 0. Normal decoding resumes FILT_LEN+3 cycles after release.

Source files
------------

// File: rtl/qsd_pkg.sv
// Shared constants and Gray-step classification
// for the quadrature step decoder.
package qsd_pkg;

   localparam int QSD_FILT_LEN = 3;

   localparam logic [1:0] QS_00 = 2'b00;
   localparam logic [1:0] QS_10 = 2'b10;
   localparam logic [1:0] QS_11 = 2'b11;
   localparam logic [1:0] QS_01 = 2'b01;

   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_UP,
      STEP_DOWN,
      STEP_ILLEGAL
   } step_t;

   // States written as {A,B}; forward order is 00,10,11,01.
   function automatic step_t qsd_step(
      input logic [1:0] prev,
      input logic [1:0] cur
   );
      step_t s;
      s = STEP_NONE;
      if (prev == cur) begin
         s = STEP_NONE;
      end else if ((prev ^ cur) == 2'b11) begin
         s = STEP_ILLEGAL;
      end else begin
         unique case (prev)
            QS_00: s = (cur == QS_10) ? STEP_UP : STEP_DOWN;
            QS_10: s = (cur == QS_11) ? STEP_UP : STEP_DOWN;
            QS_11: s = (cur == QS_01) ? STEP_UP : STEP_DOWN;
            QS_01: s = (cur == QS_00) ? STEP_UP : STEP_DOWN;
            default: s = STEP_NONE;
         endcase
      end
      return s;
   endfunction

endpackage

// File: rtl/qsd_sync_filter.sv
// Two-flop synchroniser followed by a
// consecutive-mismatch glitch filter for one bit.
module qsd_sync_filter
   import qsd_pkg::*;
#(
   parameter int FILT_LEN = QSD_FILT_LEN
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic filt
);

   logic       sync1;
   logic       sync2;
   logic [3:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         filt  <= 1'b0;
         cnt   <= 4'd0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         if (sync2 == filt) begin
            cnt <= 4'd0;
         end else if (cnt == 4'(FILT_LEN - 1)) begin
            filt <= sync2;
            cnt  <= 4'd0;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature/index front-end producing registered
// count, load, direction and error outputs.
module quad_step_decoder
   import qsd_pkg::*;
#(
   parameter int FILT_LEN = QSD_FILT_LEN
) (
   input  logic clk,
   input  logic rst,
   input  logic a_in,
   input  logic b_in,
   input  logic idx_in,
   input  logic idx_en,
   input  logic err_clr,
   output logic countup,
   output logic countdown,
   output logic load,
   output logic dir,
   output logic err
);

   localparam int PRIME = FILT_LEN + 3;

   logic       filt_a;
   logic       filt_b;
   logic       filt_i;
   logic [1:0] prev;
   logic [1:0] cur;
   logic       idx_prev;
   logic [4:0] prime_cnt;
   logic       primed;
   step_t      step;

   logic up_n;
   logic dn_n;
   logic ld_n;
   logic dir_n;
   logic err_n;

   qsd_sync_filter #(.FILT_LEN(FILT_LEN)) u_fa (
      .clk  (clk),
      .rst  (rst),
      .din  (a_in),
      .filt (filt_a)
   );

   qsd_sync_filter #(.FILT_LEN(FILT_LEN)) u_fb (
      .clk  (clk),
      .rst  (rst),
      .din  (b_in),
      .filt (filt_b)
   );

   qsd_sync_filter #(.FILT_LEN(FILT_LEN)) u_fi (
      .clk  (clk),
      .rst  (rst),
      .din  (idx_in),
      .filt (filt_i)
   );

   assign cur    = {filt_a, filt_b};
   assign primed = (prime_cnt == 5'(PRIME));
   assign step   = qsd_step(prev, cur);

   // Index wins over a coincident step; dir/err still track it.
   always_comb begin
      up_n  = 1'b0;
      dn_n  = 1'b0;
      ld_n  = 1'b0;
      dir_n = dir;
      err_n = err;
      if (err_clr) begin
         err_n = 1'b0;
      end
      if (primed) begin
         ld_n = idx_en & filt_i & ~idx_prev;
         unique case (step)
            STEP_UP: begin
               up_n  = ~ld_n;
               dir_n = 1'b1;
            end
            STEP_DOWN: begin
               dn_n  = ~ld_n;
               dir_n = 1'b0;
            end
            STEP_ILLEGAL: err_n = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         prev      <= QS_00;
         idx_prev  <= 1'b0;
         prime_cnt <= 5'd0;
         countup   <= 1'b0;
         countdown <= 1'b0;
         load      <= 1'b0;
         dir       <= 1'b0;
         err       <= 1'b0;
      end else begin
         prev     <= cur;
         idx_prev <= filt_i;
         if (!primed) begin
            prime_cnt <= prime_cnt + 5'd1;
         end
         countup   <= up_n;
         countdown <= dn_n;
         load      <= ld_n;
         dir       <= dir_n;
         err       <= err_n;
      end
   end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with a
// window-based reference model checked every cycle.
module tb_quad_step_decoder;

   localparam int F  = 3;
   localparam int P  = F + 3;
   localparam int HD = 16;

   logic clk     = 1'b0;
   logic rst     = 1'b0;
   logic a_in    = 1'b1;
   logic b_in    = 1'b1;
   logic idx_in  = 1'b0;
   logic idx_en  = 1'b0;
   logic err_clr = 1'b0;
   logic countup;
   logic countdown;
   logic load;
   logic dir;
   logic err;

   int nchk = 0;
   int nfail = 0;
   bit chk_on = 1'b0;
   int n_up = 0;
   int n_dn = 0;
   int n_ld = 0;

   quad_step_decoder #(.FILT_LEN(F)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_in      (a_in),
      .b_in      (b_in),
      .idx_in    (idx_in),
      .idx_en    (idx_en),
      .err_clr   (err_clr),
      .countup   (countup),
      .countdown (countdown),
      .load      (load),
      .dir       (dir),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Reference model: raw sample history per channel.
   bit       hist [3][HD];
   bit [2:0] mf;
   bit [2:0] nf;
   bit [2:0] raw;
   bit [1:0] mprev;
   bit       midxp;
   int       mprime;
   bit       e_up, e_dn, e_ld, e_dir, e_err;
   bit       nu, nd, nl, ndir, nerr, run;
   int       d;

   function automatic int gpos(input bit [1:0] s);
      case (s)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   always @(posedge clk) begin
      raw = {idx_in, b_in, a_in};
      if (!rst) begin
         for (int c = 0; c < 3; c++)
            for (int i = 0; i < HD; i++)
               hist[c][i] = 1'b0;
         mf = '0;
         mprev = '0;
         midxp = 1'b0;
         mprime = 0;
         {e_up, e_dn, e_ld, e_dir, e_err} = '0;
      end else begin
         nu = 0; nd = 0; nl = 0;
         ndir = e_dir;
         nerr = e_err;
         if (err_clr) nerr = 0;
         if (mprime == P) begin
            nl = idx_en && mf[2] && !midxp;
            d = (gpos({mf[0], mf[1]}) - gpos(mprev) + 4) % 4;
            if (d == 1) begin
               nu = !nl; ndir = 1;
            end else if (d == 3) begin
               nd = !nl; ndir = 0;
            end else if (d == 2) begin
               nerr = 1;
            end
         end
         // flip once the last F synchronised samples all differ
         for (int c = 0; c < 3; c++) begin
            run = 1;
            for (int i = 1; i <= F; i++)
               if (hist[c][i] == mf[c]) run = 0;
            nf[c] = run ? !mf[c] : mf[c];
         end
         mprev = {mf[0], mf[1]};
         midxp = mf[2];
         mf = nf;
         for (int c = 0; c < 3; c++) begin
            for (int i = HD - 1; i > 0; i--)
               hist[c][i] = hist[c][i-1];
            hist[c][0] = raw[c];
         end
         if (mprime < P) mprime++;
         {e_up, e_dn, e_ld, e_dir, e_err} = {nu, nd, nl, ndir, nerr};
      end
   end

   task automatic check(
      input string    nm,
      input int       act,
      input int       exp
   );
      nchk++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         nchk++;
         if ({countup, countdown, load, dir, err} !==
             {e_up, e_dn, e_ld, e_dir, e_err}) begin
            nfail++;
            $display("FAIL model t=%0t: got %b want %b", $time,
               {countup, countdown, load, dir, err},
               {e_up, e_dn, e_ld, e_dir, e_err});
         end
         n_up += int'(countup);
         n_dn += int'(countdown);
         n_ld += int'(load);
      end
   end

   // Drive raw A/B/idx now (at a negedge) and watch sel
   // for hold cycles; it must pulse only on cycle expj.
   task automatic step_chk(
      input string nm,
      input bit    na,
      input bit    nb,
      input int    sel,
      input int    expj,
      input int    hold
   );
      logic v;
      a_in = na;
      b_in = nb;
      for (int j = 1; j <= hold; j++) begin
         @(negedge clk);
         v = (sel == 0) ? countup : countdown;
         check(nm, int'(v), int'(j == expj));
      end
   endtask

   int u0, d0, l0;

   initial begin
      // reset with inputs at 11, then priming
      repeat (2) @(negedge clk);
      chk_on = 1'b1;
      check("reset_outs",
         int'({countup, countdown, load, dir, err}), 0);
      rst = 1'b1;
      u0 = n_up; d0 = n_dn;
      repeat (20) @(negedge clk);
      check("prime_no_up", n_up - u0, 0);
      check("prime_no_dn", n_dn - d0, 0);
      check("prime_err", int'(err), 0);

      // forward sequence from a clean 00 start
      rst = 1'b0;
      a_in = 1'b0;
      b_in = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      u0 = n_up; d0 = n_dn;
      step_chk("fwd_10", 1, 0, 0, 6, 8);
      step_chk("fwd_11", 1, 1, 0, 6, 8);
      step_chk("fwd_01", 0, 1, 0, 6, 8);
      step_chk("fwd_00", 0, 0, 0, 6, 8);
      check("fwd_count", n_up - u0, 4);
      check("fwd_no_dn", n_dn - d0, 0);
      check("fwd_dir", int'(dir), 1);

      // reverse sequence, then a short glitch on A
      u0 = n_up; d0 = n_dn;
      step_chk("rev_01", 0, 1, 1, 6, 8);
      step_chk("rev_11", 1, 1, 1, 6, 8);
      step_chk("rev_10", 1, 0, 1, 6, 8);
      step_chk("rev_00", 0, 0, 1, 6, 8);
      check("rev_count", n_dn - d0, 4);
      check("rev_no_up", n_up - u0, 0);
      check("rev_dir", int'(dir), 0);
      u0 = n_up; d0 = n_dn;
      a_in = 1'b1;
      repeat (2) @(negedge clk);
      a_in = 1'b0;
      repeat (10) @(negedge clk);
      check("glitch_up", n_up - u0, 0);
      check("glitch_dn", n_dn - d0, 0);

      // illegal double transition and err_clr handling
      u0 = n_up; d0 = n_dn;
      step_chk("illeg_up", 1, 1, 0, 0, 8);
      check("illeg_err", int'(err), 1);
      check("illeg_no_dn", n_dn - d0, 0);
      check("illeg_dir", int'(dir), 0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("err_cleared", int'(err), 0);
      a_in = 1'b0;
      b_in = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         if (j == 5) err_clr = 1'b1;
         if (j == 6) begin
            err_clr = 1'b0;
            check("err_set_wins", int'(err), 1);
         end
      end
      check("illeg2_err", int'(err), 1);
      check("illeg2_no_up", n_up - u0, 0);

      // index with a coincident forward step
      idx_en = 1'b1;
      u0 = n_up; l0 = n_ld;
      a_in = 1'b1;
      idx_in = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         if (j == 6) begin
            idx_in = 1'b0;
            check("idx_load", int'(load), 1);
            check("idx_up_masked", int'(countup), 0);
         end
      end
      repeat (4) @(negedge clk);
      check("idx_load_cnt", n_ld - l0, 1);
      check("idx_up_cnt", n_up - u0, 0);

      idx_en = 1'b0;
      u0 = n_up; l0 = n_ld;
      b_in = 1'b1;
      idx_in = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         if (j == 6) begin
            idx_in = 1'b0;
            check("noidx_load", int'(load), 0);
            check("noidx_up", int'(countup), 1);
         end
      end
      repeat (4) @(negedge clk);
      check("noidx_load_cnt", n_ld - l0, 0);

      // reset while a step is in flight (11 -> 01)
      u0 = n_up; d0 = n_dn;
      a_in = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         if (j == 3) rst = 1'b0;
         if (j == 4) begin
            rst = 1'b1;
            check("midrst_outs",
               int'({countup, countdown, load, dir, err}), 0);
         end
      end
      repeat (12) @(negedge clk);
      check("midrst_no_up", n_up - u0, 0);
      check("midrst_no_dn", n_dn - d0, 0);
      check("midrst_err", int'(err), 0);
      step_chk("resume_00", 0, 0, 0, 6, 8);
      check("resume_cnt", n_up - u0, 1);
      check("resume_dir", int'(dir), 1);

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
         nchk, nfail);
      $finish;
   end

endmodule
